// File: rtl/lap_stopwatch.sv
// Up/down minutes:seconds stopwatch with on-chip prescaler
// and a first-word fall-through lap-capture FIFO.
module lap_stopwatch #(
    parameter int TICK_DIV  = 100,
    parameter int MIN_W     = 8,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    input  logic             lap,
    input  logic             lap_rd,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [1:0]       status,
    output logic             expired,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic             lap_valid,
    output logic             lap_full,
    output logic             lap_ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CFULL = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             exp_q, exp_d;

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [MIN_W-1:0] mem_min_q [LAP_DEPTH];
    logic [5:0]       mem_sec_q [LAP_DEPTH];

    logic tick;
    logic ld_ok;
    logic lap_ok;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        exp_d   = 1'b0;
        tick    = (state_q == ST_RUN) && (presc_q == PMAX);
        ld_ok   = load && (state_q == ST_IDLE || state_q == ST_DONE);

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && !mode_q) begin
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    min_d = min_q + 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else if (tick) begin
                if (sec_q == 6'd0) begin
                    sec_d = 6'd59;
                    min_d = min_q - 1'b1;
                end else begin
                    sec_d = sec_q - 1'b1;
                end
                if (min_q == '0 && sec_q == 6'd1) begin
                    state_d = ST_DONE;
                    exp_d   = 1'b1;
                end
            end
        end

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            min_d   = '0;
            sec_d   = '0;
            exp_d   = 1'b0;
        end else if (ld_ok) begin
            state_d = ST_IDLE;
            presc_d = '0;
            min_d   = load_min;
            sec_d   = (load_sec > 6'd59) ? 6'd59 : load_sec;
        end else if (stop && state_q == ST_RUN) begin
            // the final countdown tick beats a coincident pause
            if (!exp_d) state_d = ST_PAUSE;
        end else if (start) begin
            if (state_q == ST_IDLE &&
                !(mode && min_q == '0 && sec_q == 6'd0)) begin
                state_d = ST_RUN;
                mode_d  = mode;
                presc_d = '0;
            end else if (state_q == ST_PAUSE) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        full   = (cnt_q == CFULL);
        lap_ok = lap && (state_q == ST_RUN || state_q == ST_PAUSE);
        pop    = !clear && lap_rd && (cnt_q != '0);
        push   = !clear && lap_ok && (!full || pop);
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clear) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop) rp_d = rp_q + 1'b1;
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            if (pop && !push) cnt_d = cnt_q - 1'b1;
            if (lap_ok && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            presc_q <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            exp_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            exp_q   <= exp_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // lap snapshots take the pre-tick time held in min_q/sec_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_min_q[i] <= '0;
                mem_sec_q[i] <= '0;
            end
        end else if (push) begin
            mem_min_q[wp_q] <= min_q;
            mem_sec_q[wp_q] <= sec_q;
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign status    = state_q;
    assign expired   = exp_q;
    assign lap_valid = (cnt_q != '0);
    assign lap_full  = full;
    assign lap_ovf   = ovf_q;
    assign lap_min   = lap_valid ? mem_min_q[rp_q] : '0;
    assign lap_sec   = lap_valid ? mem_sec_q[rp_q] : '0;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: total-seconds reference model,
// directed scenarios and randomized pulse traffic.
module tb_lap_stopwatch;

    localparam int TD = 2;
    localparam int MW = 2;
    localparam int LD = 4;
    localparam int TOTAL = (1 << MW) * 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 0, stop = 0, clear = 0, mode = 0;
    logic load = 0, lap = 0, lap_rd = 0;
    logic [MW-1:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic [MW-1:0] minutes, lap_min;
    logic [5:0] seconds, lap_sec;
    logic [1:0] status;
    logic expired, lap_valid, lap_full, lap_ovf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // model: state 0 idle 1 run 2 pause 3 done, time in total seconds
    int m_st, m_ph, m_t;
    bit m_down, m_exp, m_ovf;
    int m_q[$];

    lap_stopwatch #(.TICK_DIV(TD), .MIN_W(MW), .LAP_DEPTH(LD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .clear(clear), .mode(mode), .load(load),
        .load_min(load_min), .load_sec(load_sec),
        .lap(lap), .lap_rd(lap_rd),
        .minutes(minutes), .seconds(seconds), .status(status),
        .expired(expired), .lap_min(lap_min), .lap_sec(lap_sec),
        .lap_valid(lap_valid), .lap_full(lap_full), .lap_ovf(lap_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_ph = 0; m_t = 0;
        m_down = 0; m_exp = 0; m_ovf = 0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        int nt, nst, nph, snap, ls;
        bit lap_ok, pop, full;
        nt = m_t; nst = m_st; nph = m_ph; snap = m_t;
        m_exp = 0;
        lap_ok = lap && (m_st == 1 || m_st == 2);
        pop = lap_rd && (m_q.size() > 0);
        full = (m_q.size() == LD);
        if (m_st == 1) begin
            if (m_ph == TD - 1) begin
                nph = 0;
                if (!m_down) nt = (m_t + 1) % TOTAL;
                else begin
                    nt = m_t - 1;
                    if (nt == 0) begin nst = 3; m_exp = 1; end
                end
            end else nph = m_ph + 1;
        end
        if (clear) begin
            nst = 0; nt = 0; nph = 0; m_exp = 0;
            m_q.delete(); m_ovf = 0;
        end else begin
            if (load && (m_st == 0 || m_st == 3)) begin
                ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
                nst = 0; nph = 0; nt = int'(load_min) * 60 + ls;
            end else if (stop && m_st == 1) begin
                if (nst != 3) nst = 2;
            end else if (start && m_st == 0) begin
                if (!(mode && m_t == 0)) begin
                    nst = 1; m_down = mode; nph = 0;
                end
            end else if (start && m_st == 2) nst = 1;
            if (pop) m_q.delete(0);
            if (lap_ok) begin
                if (!full || pop) m_q.push_back(snap);
                else m_ovf = 1;
            end
        end
        m_t = nt; m_st = nst; m_ph = nph;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("minutes", int'(minutes), m_t / 60);
            chk("seconds", int'(seconds), m_t % 60);
            chk("status", int'(status), m_st);
            chk("expired", int'(expired), int'(m_exp));
            chk("lap_valid", int'(lap_valid), int'(m_q.size() > 0));
            chk("lap_full", int'(lap_full), int'(m_q.size() == LD));
            chk("lap_ovf", int'(lap_ovf), int'(m_ovf));
            chk("lap_min", int'(lap_min),
                (m_q.size() > 0) ? m_q[0] / 60 : 0);
            chk("lap_sec", int'(lap_sec),
                (m_q.size() > 0) ? m_q[0] % 60 : 0);
        end
    end

    task automatic go();
        @(negedge clk);
        start = 0; stop = 0; clear = 0;
        load = 0; lap = 0; lap_rd = 0;
    endtask

    task automatic gon(int n);
        repeat (n) go();
    endtask

    task automatic ldt(int mi, int se);
        load_min = MW'(mi); load_sec = 6'(se); load = 1; go();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        chk_en = 1;
        go();
        chk("rst_status", int'(status), 0);
        chk("rst_time", int'(seconds) + int'(minutes), 0);

        mode = 0; start = 1; go();
        chk("run_status", int'(status), 1);
        gon(120);
        chk("up_min", int'(minutes), 1);
        chk("up_sec", int'(seconds), 0);

        clear = 1; go();
        start = 1; go();
        gon(14);
        chk("at7", int'(seconds), 7);
        stop = 1; go();
        gon(50);
        chk("pause_sec", int'(seconds), 7);
        chk("pause_st", int'(status), 2);
        start = 1; go();
        chk("resume_sec", int'(seconds), 7);
        go();
        chk("resume_tick", int'(seconds), 8);

        clear = 1; go();
        ldt(0, 3);
        mode = 1; start = 1; go();
        gon(2);
        chk("dn2", int'(seconds), 2);
        gon(4);
        chk("dn0", int'(seconds), 0);
        chk("expired", int'(expired), 1);
        chk("done_st", int'(status), 3);
        go();
        chk("exp_once", int'(expired), 0);
        start = 1; go();
        chk("done_hold", int'(status), 3);
        clear = 1; go();
        chk("clr_st", int'(status), 0);

        ldt(3, 58);
        mode = 0; start = 1; go();
        gon(2);
        chk("w359", int'(minutes) * 60 + int'(seconds), 239);
        gon(2);
        chk("wrap0", int'(minutes) * 60 + int'(seconds), 0);
        chk("wrap_st", int'(status), 1);

        clear = 1; go();
        start = 1; go();
        repeat (5) begin
            lap = 1; go();
            gon(3);
        end
        chk("lfull", int'(lap_full), 1);
        chk("lovf", int'(lap_ovf), 1);
        chk("lhead0", int'(lap_sec), 0);
        stop = 1; go();
        lap_rd = 1; go();
        chk("lhead1", int'(lap_sec), 2);
        repeat (3) begin lap_rd = 1; go(); end
        chk("lempty", int'(lap_valid), 0);

        clear = 1; go();
        start = 1; go();
        go();
        lap = 1; go();
        chk("lap_pre", int'(lap_sec), 0);
        chk("lap_post", int'(seconds), 1);
        start = 1; stop = 1; go();
        chk("ss_pause", int'(status), 2);
        clear = 1; go();
        ldt(2, 63);
        chk("clamp", int'(seconds), 59);
        load_min = 2; load_sec = 30; clear = 1; load = 1; go();
        chk("clr_ld", int'(minutes) * 60 + int'(seconds), 0);

        start = 1; go();
        gon(7);
        #2 rst = 1;
        #1;
        chk("arst_time", int'(minutes) * 60 + int'(seconds), 0);
        chk("arst_st", int'(status), 0);
        go();
        rst = 0;
        go();

        repeat (3000) begin
            start = ($urandom_range(0, 99) < 10);
            stop = ($urandom_range(0, 99) < 6);
            clear = ($urandom_range(0, 99) < 2);
            load = ($urandom_range(0, 99) < 5);
            lap = ($urandom_range(0, 99) < 15);
            lap_rd = ($urandom_range(0, 99) < 12);
            mode = 1'($urandom_range(0, 1));
            load_min = MW'($urandom_range(0, (1 << MW) - 1));
            load_sec = 6'($urandom_range(0, 63));
            go();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised stopwatch/timer core. It can count up or down in minutes and seconds and has an on-chip prescaler. A lap-capture FIFO stores split times. It replaces the fixed-width, free-running-tick stopwatch_top and is driven by the same one-cycle start/stop/clear control pulses from the button-synchroniser layer.

Parameters:
TICK_DIV 100 clk cycles per one-second increment; must be >= 1, and 1 means every cycle.
MIN_W 8 width of the minutes field.
LAP_DEPTH 4 lap FIFO entries; power of 2 and >= 2.

Ports:
clk in 1 system clock, rising edge
rst in 1 asynchronous, active-high reset
start in 1 one-cycle pulse: run or resume
stop in 1 one-cycle pulse: pause
clear in 1 one-cycle pulse: synchronous return to IDLE with 0:00
mode in 1 0 = count up, 1 = count down; sampled on start from IDLE
load in 1 one-cycle pulse: preset the time from load_min/load_sec
load_min in MIN_W preset minutes
load_sec in 6 preset seconds, 0..59
lap in 1 one-cycle pulse: push the current time into the FIFO
lap_rd in 1 pop the FIFO head
minutes out MIN_W current minutes
seconds out 6 current seconds, 0..59
status out 2 00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
expired out 1 one-cycle pulse when the countdown reaches 0:00
lap_min out MIN_W FIFO head minutes (first-word fall-through)
lap_sec out 6 FIFO head seconds
lap_valid out 1 FIFO not empty
lap_full out 1 FIFO holds LAP_DEPTH entries
lap_ovf out 1 sticky: a lap was dropped because the FIFO was full

Behaviour:
- Reset (rst=1, asynchronous) sets every output and internal register to 0: status=IDLE, time 0:00, FIFO empty, prescaler 0, lap_ovf=0, latched mode=up.
- Control priority when several pulses coincide: clear > load > stop > start.
- clear: accepted in any state. Next cycle: IDLE, 0:00, prescaler 0, FIFO empty, lap_ovf=0.
- load: accepted only in IDLE or DONE; state becomes IDLE. load_sec > 59 is clamped to 59. Ignored in RUNNING and PAUSED.
- State transitions:
  - IDLE + start → RUNNING. Latches mode and clears the prescaler. Exception: start in down mode at 0:00 is ignored and the state stays IDLE.
  - RUNNING + stop → PAUSED. The prescaler holds its value.
  - PAUSED + start → RUNNING. The prescaler resumes from its held value; it is not cleared.
  - DONE + start → ignored. Only clear or load leaves DONE.
  - stop in IDLE, PAUSED or DONE → ignored.
- Prescaler counts 0..TICK_DIV-1 only in RUNNING. A tick fires in the cycle it equals TICK_DIV-1, and it then wraps to 0. The first tick after start from IDLE is TICK_DIV cycles later. Time registers update on the clock edge ending the tick cycle.
- Up count: seconds 59 → 0 and minutes +1. From all-ones minutes with seconds 59, the time wraps to 0:00 and the state stays RUNNING.
- Down count: seconds 0 → 59 and minutes −1. A tick at 0:01 gives 0:00; the state becomes DONE and expired=1 for exactly that one cycle. No further ticks occur in DONE.
- Lap capture:
  - Accepted in RUNNING or PAUSED and ignored otherwise.
  - Stores the time value present in the cycle lap is high, i.e. the pre-tick value if a tick coincides.
  - If the FIFO is full and lap_rd is low, the entry is dropped and lap_ovf is set.
  - Simultaneous lap and lap_rd when full: the pop and push both occur and no overflow is flagged.
  - lap_rd when empty is ignored.
- lap_min/lap_sec are the head entry whenever lap_valid=1 and 0 otherwise. Pop takes effect on the next edge.
- clear in the same cycle as lap or lap_rd: clear wins and the FIFO ends empty.
- Reset asserted mid-count forces all state to the reset values at once, independent of clk.

Test Plan:
- TICK_DIV=2: rst, then start (mode=0) → status=01; after 120 cycles minutes=1, seconds=0; no tick is missed at the 59→0 wrap.
- Run to 0:07, stop, wait 50 cycles, start → time stays 0:07 while status=10; 0:08 arrives 2 cycles after the prescaler phase in which it was paused.
- load 0:03 with mode=1, start → 0:02, 0:01, 0:00 on successive ticks; expired is high for 1 cycle; status=11; start is then ignored; clear gives 00 and 0:00.
- MIN_W=2 up count from load 3:58 → 3:59, then 0:00 with status staying 01.
- LAP_DEPTH=4: 5 lap pulses at distinct times → lap_full=1, lap_ovf=1; 4 pops return the first 4 times in order, then lap_valid=0.
- Coincidences:
  - lap on a tick cycle stores the pre-tick value.
  - start+stop in the same cycle while RUNNING → PAUSED.
  - clear+load → 0:00.
  - rst asserted mid-run between clock edges → outputs 0 before the next edge.
